// File: rtl/fft_frame_loader.sv
// fft_frame_loader: ping-pong input stage in front of the 32-point butterfly FFT core.
// Complex samples stream in over valid/ready. Each group of N_POINTS samples is
// assembled into one parallel frame, which is held on frame_out until the core
// acknowledges it. The other bank keeps filling while a frame is held.
// Build option FFT_BITREV_EN: sample i is stored in slot bitrev(i), which is
// decimation-in-time order. Without it, sample i is stored in slot i.
module fft_frame_loader #(
    parameter int N_POINTS = 32,
    parameter int LOG2N    = 5,
    parameter int SAMPLE_W = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SAMPLE_W-1:0]          in_data,
    input  logic                         in_last,
    output logic [N_POINTS*SAMPLE_W-1:0] frame_out,
    output logic                         frame_valid,
    input  logic                         frame_ack,
    output logic                         frame_err,
    output logic [LOG2N:0]               fill_count
);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_PRESENTED
    } bank_state_t;

    bank_state_t                 state_q [2];
    bank_state_t                 state_d [2];
    logic [SAMPLE_W-1:0]         bank_q  [2][N_POINTS];
    logic [SAMPLE_W-1:0]         bank_d  [2][N_POINTS];
    logic                        wr_ptr_q, wr_ptr_d;
    logic                        rd_ptr_q, rd_ptr_d;
    logic [LOG2N-1:0]            idx_q, idx_d;
    logic [N_POINTS*SAMPLE_W-1:0] frame_out_q, frame_out_d;
    logic                        frame_valid_q, frame_valid_d;
    logic                        frame_err_q, frame_err_d;
    logic                        ready_en_q, ready_en_d;
    logic                        accept;
    logic                        ack_take;

    // Map an arrival index to its storage slot.
    function automatic logic [LOG2N-1:0] slot_of(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] slot;
`ifdef FFT_BITREV_EN
        for (int b = 0; b < LOG2N; b++) begin
            slot[b] = idx[LOG2N-1-b];
        end
`else
        slot = idx;
`endif
        return slot;
    endfunction

    // A bank holds a complete frame, either waiting or on the output bus.
    function automatic logic is_occupied(input bank_state_t s);
        return (s == BANK_FULL) || (s == BANK_PRESENTED);
    endfunction

    // Outputs come only from registered state, so in_ready never depends on in_valid.
    assign in_ready    = ready_en_q && !(is_occupied(state_q[0]) && is_occupied(state_q[1]));
    assign frame_out   = frame_out_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign fill_count  = is_occupied(state_q[wr_ptr_q]) ? (LOG2N+1)'(N_POINTS)
                                                        : {1'b0, idx_q};
    assign accept      = in_valid && in_ready;
    assign ack_take    = frame_ack && frame_valid_q;

    // Next-state logic: accept samples, release acked frames, present the next full bank.
    always_comb begin
        state_d       = state_q;
        bank_d        = bank_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        idx_d         = idx_q;
        frame_out_d   = frame_out_q;
        frame_valid_d = frame_valid_q;
        frame_err_d   = 1'b0;
        ready_en_d    = 1'b1;

        if (accept) begin
            bank_d[wr_ptr_q][slot_of(idx_q)] = in_data;
            if (idx_q == LOG2N'(N_POINTS - 1)) begin
                state_d[wr_ptr_q] = BANK_FULL;
                wr_ptr_d          = ~wr_ptr_q;
                idx_d             = '0;
            end else if (in_last) begin
                state_d[wr_ptr_q] = BANK_EMPTY;
                idx_d             = '0;
                frame_err_d       = 1'b1;
            end else begin
                state_d[wr_ptr_q] = BANK_FILLING;
                idx_d             = idx_q + LOG2N'(1);
            end
        end

        if (ack_take) begin
            state_d[rd_ptr_q] = BANK_EMPTY;
            rd_ptr_d          = ~rd_ptr_q;
            frame_valid_d     = 1'b0;
        end

        // A bank that completes on this same edge is presented right after it.
        if (!frame_valid_d && (state_d[rd_ptr_d] == BANK_FULL)) begin
            state_d[rd_ptr_d] = BANK_PRESENTED;
            frame_valid_d     = 1'b1;
            for (int k = 0; k < N_POINTS; k++) begin
                frame_out_d[k*SAMPLE_W +: SAMPLE_W] = bank_d[rd_ptr_d][k];
            end
        end
    end

    // State registers. Reset clears everything, so no pre-reset frame can appear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= BANK_EMPTY;
                for (int k = 0; k < N_POINTS; k++) begin
                    bank_q[b][k] <= '0;
                end
            end
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            idx_q         <= '0;
            frame_out_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            ready_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            bank_q        <= bank_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            idx_q         <= idx_d;
            frame_out_q   <= frame_out_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            ready_en_q    <= ready_en_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader: scoreboard bench for fft_frame_loader.
// Completed frames are queued as samples are driven. They are popped when the
// loader should present them, and every cycle's outputs are compared.
// Build option FFT_BITREV_EN selects bit-reversed slot placement.
module tb_fft_frame_loader;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int SW    = 64;
    localparam int FW    = N * SW;
`ifdef FFT_BITREV_EN
    localparam int SLOT5 = 20;
`else
    localparam int SLOT5 = 5;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [SW-1:0]   in_data;
    logic            in_last;
    logic [FW-1:0]   frame_out;
    logic            frame_valid;
    logic            frame_ack;
    logic            frame_err;
    logic [LOG2N:0]  fill_count;

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] build_frame;
    logic [FW-1:0] mdl_frame;
    int            bidx;
    bit            mdl_valid;
    bit            mdl_err;
    bit            mdl_ready;
    bit            mdl_ready_en;
    int            mdl_fill;
    int            frames_done = 0;

    always #5 clk = ~clk;

    fft_frame_loader #(.N_POINTS(N), .LOG2N(LOG2N), .SAMPLE_W(SW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .frame_out(frame_out),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_err(frame_err),
        .fill_count(fill_count)
    );

    function automatic int slot_of(input int idx);
`ifdef FFT_BITREV_EN
        int s = 0;
        for (int b = 0; b < LOG2N; b++) if (idx[b]) s = s | (1 << (LOG2N - 1 - b));
        return s;
`else
        return idx;
`endif
    endfunction

    function automatic logic [SW-1:0] pat(input int v);
        logic [31:0] w;
        w = 32'(v);
        return {w, ~w};
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        build_frame  = '0;
        mdl_frame    = '0;
        bidx         = 0;
        mdl_valid    = 0;
        mdl_err      = 0;
        mdl_ready    = 0;
        mdl_ready_en = 0;
        mdl_fill     = 0;
    endfunction

    // One clock cycle. Drive at negedge, update the model at the edge, compare at the next negedge.
    task automatic drive_cycle(input bit v, input logic [SW-1:0] d, input bit last, input bit ack);
        bit acc, ackt;
        int occ, bad;
        in_valid = v; in_data = d; in_last = last; frame_ack = ack;
        acc  = v && mdl_ready;
        ackt = ack && mdl_valid;
        @(posedge clk);
        mdl_err = 0;
        if (acc) begin
            build_frame[slot_of(bidx)*SW +: SW] = d;
            if (bidx == N - 1) begin
                exp_q.push_back(build_frame);
                bidx = 0;
                frames_done++;
            end else if (last) begin
                bidx = 0;
                mdl_err = 1;
            end else begin
                bidx++;
            end
        end
        if (ackt) mdl_valid = 0;
        if (!mdl_valid && exp_q.size() > 0) begin
            mdl_frame = exp_q.pop_front();
            mdl_valid = 1;
        end
        mdl_ready_en = 1;
        occ       = int'(mdl_valid) + exp_q.size();
        mdl_ready = mdl_ready_en && (occ < 2);
        mdl_fill  = (occ == 2) ? N : bidx;
        @(negedge clk);
        in_valid = 0; in_last = 0; frame_ack = 0;
        checks++;
        if (frame_out !== mdl_frame) begin
            errors++;
            bad = 0;
            for (int k = N - 1; k >= 0; k--) if (frame_out[k*SW +: SW] !== mdl_frame[k*SW +: SW]) bad = k;
            $display("[TB] FAIL frame_out slot %0d: got %h expected %h", bad,
                     frame_out[bad*SW +: SW], mdl_frame[bad*SW +: SW]);
        end
        checks++;
        if (frame_valid !== mdl_valid) begin
            errors++; $display("[TB] FAIL frame_valid: got %b expected %b", frame_valid, mdl_valid);
        end
        checks++;
        if (in_ready !== mdl_ready) begin
            errors++; $display("[TB] FAIL in_ready: got %b expected %b", in_ready, mdl_ready);
        end
        checks++;
        if (frame_err !== mdl_err) begin
            errors++; $display("[TB] FAIL frame_err: got %b expected %b", frame_err, mdl_err);
        end
        checks++;
        if (fill_count !== (LOG2N+1)'(mdl_fill)) begin
            errors++; $display("[TB] FAIL fill_count: got %0d expected %0d", fill_count, mdl_fill);
        end
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; in_data = '0; in_last = 0; frame_ack = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset frame_valid: got %b expected 0", frame_valid); end
        checks++; if (frame_out !== '0) begin errors++; $display("[TB] FAIL reset frame_out: got nonzero expected 0"); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset frame_err: got %b expected 0", frame_err); end
        checks++; if (fill_count !== '0) begin errors++; $display("[TB] FAIL reset fill_count: got %0d expected 0", fill_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset in_ready: got %b expected 0", in_ready); end
        reset = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL release in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        drive_cycle(0, '0, 0, 0);
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < N; i++) drive_cycle(1, pat(i), i == N - 1, 0);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL single frame_valid: got %b expected 1", frame_valid); end
        checks++; if (frame_out[SLOT5*SW +: SW] !== {32'd5, ~32'd5}) begin
            errors++; $display("[TB] FAIL single slot5: got %h expected %h", frame_out[SLOT5*SW +: SW], {32'd5, ~32'd5});
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) drive_cycle(1, pat(i + 100), 0, 0);
        checks++; if (fill_count !== 6'd32) begin errors++; $display("[TB] FAIL bp fill_count: got %0d expected 32", fill_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp in_ready: got %b expected 0", in_ready); end
        drive_cycle(1, pat(999), 0, 0);
        checks++; if (frame_out[SLOT5*SW +: SW] !== {32'd5, ~32'd5}) begin
            errors++; $display("[TB] FAIL bp held slot5: got %h expected %h", frame_out[SLOT5*SW +: SW], {32'd5, ~32'd5});
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(0, '0, 0, 1);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b frame_valid: got %b expected 1", frame_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b in_ready: got %b expected 1", in_ready); end
        checks++; if (frame_out[SLOT5*SW +: SW] !== {32'd105, ~32'd105}) begin
            errors++; $display("[TB] FAIL b2b slot5: got %h expected %h", frame_out[SLOT5*SW +: SW], {32'd105, ~32'd105});
        end
        drive_cycle(0, '0, 0, 1);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b second ack frame_valid: got %b expected 0", frame_valid); end
    endtask

    task automatic test_short_frame();
        for (int i = 0; i < 10; i++) drive_cycle(1, pat(i + 200), i == 9, 0);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL short frame_err: got %b expected 1", frame_err); end
        checks++; if (fill_count !== '0) begin errors++; $display("[TB] FAIL short fill_count: got %0d expected 0", fill_count); end
        drive_cycle(0, '0, 0, 1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL short err pulse width: got %b expected 0", frame_err); end
        for (int i = 0; i < N; i++) drive_cycle(1, pat(i + 300), 0, 0);
        checks++; if (frame_out[SLOT5*SW +: SW] !== {32'd305, ~32'd305}) begin
            errors++; $display("[TB] FAIL short clean slot5: got %h expected %h", frame_out[SLOT5*SW +: SW], {32'd305, ~32'd305});
        end
        drive_cycle(0, '0, 0, 1);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < N; i++) drive_cycle(1, pat(i + 400), 0, 0);
        for (int i = 0; i < 17; i++) drive_cycle(1, pat(i + 500), 0, 0);
        checks++; if (fill_count !== 6'd17) begin errors++; $display("[TB] FAIL midreset fill_count before: got %0d expected 17", fill_count); end
        #2 reset = 1;
        #1;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset frame_valid: got %b expected 0", frame_valid); end
        checks++; if (frame_out !== '0) begin errors++; $display("[TB] FAIL midreset frame_out: got nonzero expected 0"); end
        checks++; if (fill_count !== '0) begin errors++; $display("[TB] FAIL midreset fill_count: got %0d expected 0", fill_count); end
        model_reset();
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 40; i++) drive_cycle(0, '0, 0, i[0]);
    endtask

    task automatic test_random();
        int cycles = 0;
        int target = frames_done + 100;
        bit v, last, ack;
        while ((frames_done < target || mdl_valid || exp_q.size() > 0) && cycles < 30000) begin
            v    = ($urandom_range(0, 1) == 1) && (frames_done < target);
            last = (bidx == N - 1) && ($urandom_range(0, 1) == 1);
            ack  = ($urandom_range(0, 2) == 0);
            drive_cycle(v, {$urandom, $urandom}, last, ack);
            cycles++;
        end
        checks++; if (cycles >= 30000) begin errors++; $display("[TB] FAIL random drain: got %0d cycles expected < 30000", cycles); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_short_frame();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Input stage directly upstream of the 32-point butterfly FFT core.
- Accepts complex time samples streamed one per cycle over a valid/ready handshake.
- Assembles each group of 32 samples into one 2048-bit parallel frame and holds that frame stable on the core's input bus until the consumer acknowledges it.
- Uses two ping-pong banks, so the next frame can fill while the current frame is held.

Parameters:
- N_POINTS, 32, samples per frame; must be a power of two.
- LOG2N, 5, log2(N_POINTS); width of the sample index.
- SAMPLE_W, 64, complex sample width: [63:32] real, [31:0] imag, each signed two's complement.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader can accept a sample this cycle.
- in_data  in  SAMPLE_W  complex time sample.
- in_last  in  1  marks the final sample of a frame.
- frame_out  out  N_POINTS*SAMPLE_W  assembled frame; slot k occupies bits [64k+63:64k].
- frame_valid  out  1  frame_out holds a complete frame.
- frame_ack  in  1  consumer has taken frame_out; sampled only while frame_valid=1.
- frame_err  out  1  one-cycle pulse when a short frame is discarded.
- fill_count  out  LOG2N+1  number of samples in the bank currently being written (0..32).

Behaviour:
- Reset: asserting reset immediately (asynchronously) drives all of the following:
  - frame_out = 0, frame_valid = 0, frame_err = 0, fill_count = 0, in_ready = 0.
  - Both banks EMPTY; write pointer on bank 0; read pointer on bank 0.
  - in_ready rises on the first clock edge after reset deasserts.
- Reset mid-frame discards all partial and held data; no frame_valid results from pre-reset samples.
- Accept rule: a sample is accepted at a rising edge with in_valid=1 and in_ready=1. in_data is written to the write bank at index fill_count, and fill_count increments.
- Bank states: EMPTY, FILLING, FULL, PRESENTED.
  - EMPTY -> FILLING on the first accept.
  - FILLING -> FULL on the accept of sample index 31.
  - FULL -> PRESENTED when the read pointer selects the bank.
  - PRESENTED -> EMPTY on frame_ack.
- Write pointer: toggles to the other bank when the current bank becomes FULL. fill_count then shows 0.
- in_ready: equals 1 unless both banks are FULL or PRESENTED. Combinationally derived from registered state only; it never depends on in_valid.
- Presentation latency: the sample-31 accept at edge k makes frame_valid=1 and frame_out valid after edge k, provided no other frame is being presented.
- frame_out and frame_valid are registered. frame_out is held constant while frame_valid=1 and no ack has been taken.
- Ack rule: frame_ack=1 with frame_valid=1 at an edge releases the presented bank.
  - If the other bank is FULL, frame_out switches to it and frame_valid stays 1 (back-to-back, no bubble).
  - Otherwise frame_valid drops to 0. frame_out keeps its last value.
- frame_ack while frame_valid=0 is ignored.
- Short frame: in_last=1 on an accepted sample with index < 31 causes all of the following:
  - The partial bank returns to EMPTY and fill_count returns to 0 on the next cycle.
  - frame_err pulses high for exactly one cycle.
  - No frame is produced.
- Frame end without marker: the accept of sample index 31 completes the frame whether in_last is 0 or 1. No error is flagged.
- Simultaneous events:
  - Sample-31 accept into bank B in the same edge as an ack of bank A: bank B is presented next cycle, frame_valid stays 1, in_ready stays 1.
  - Ack in the same edge as an accept while both banks are occupied cannot occur, because in_ready=0 then.
  - in_ready returns to 1 one cycle after the ack.
- Arithmetic: samples are stored bit-exact; no scaling, no rounding.

Optional Feature:
- Macro: FFT_BITREV_EN.
- Defined: sample index i is stored in slot bitrev5(i). Example: index 1 goes to slot 16 and index 3 goes to slot 24. This lets the core consume decimation-in-time input order directly.
- Undefined: natural order; sample i goes to slot i.
- Handshake, latency and error behaviour are identical in both builds.

Test Plan:
- Reset, then stream samples i=0..31 with in_data={i,~i}, in_valid held 1 -> frame_valid=1 one cycle after the 32nd accept. Slot 5 = {32'd5, ~32'd5} (natural build) or sits in slot 20 (FFT_BITREV_EN build).
- Hold frame_ack=0 and stream 32 more samples -> second bank fills, then in_ready=0. fill_count=32. frame_out still equals frame 1.
- Pulse frame_ack once -> next cycle frame_out = frame 2, frame_valid stays 1, in_ready=1. A second ack gives frame_valid=0.
- Stream 10 samples, the 10th with in_last=1 -> frame_err high for exactly 1 cycle, fill_count=0. The following 32 samples produce one clean frame.
- Assert reset asynchronously mid-fill at sample 17 while a frame is presented -> frame_valid=0, frame_out=0, fill_count=0 immediately. No stale frame appears after release.
- Random in_valid gaps (50%) and random frame_ack timing over 100 frames -> every frame matches the scoreboard in order. No sample is lost or duplicated, and frame_out is never altered while frame_valid=1 without an ack.
